// File: rtl/region_embedder_pkg.sv
// Shared video-path definitions: pixel width and the black pixel constant.
package region_embedder_pkg;

  localparam int PIX_W = 24;

  typedef logic [PIX_W-1:0] pixel_t;

  localparam pixel_t PIX_BLACK = 24'h000000;

endpackage

// File: rtl/region_embedder_vp_sync_fifo.sv
// Single-clock pixel FIFO with registered read data, push/pop/flush and full/empty flags.
module vp_sync_fifo
  import region_embedder_pkg::*;
#(
  parameter int FIFO_AW = 11,
  parameter int DATA_W  = PIX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               push_ok;
  logic               pop_ok;

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign pop_ok  = pop && !empty && !flush;
  assign push_ok = push && (!full || pop_ok) && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (pop_ok) rd_data <= mem[rd_ptr];
  end

endmodule

// File: rtl/region_embedder.sv
// Re-embeds a buffered cropped pixel stream into a full-frame timing, filling outside the window.
module region_embedder
  import region_embedder_pkg::*;
#(
  parameter logic [11:0] H_DISP      = 12'd1280,
  parameter logic [11:0] V_DISP      = 12'd720,
  parameter int          X_RES_WIDTH = 11,
  parameter int          Y_RES_WIDTH = 11,
  parameter int          FIFO_AW     = 11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   EN,
  input  logic [X_RES_WIDTH-1:0] START_X,
  input  logic [X_RES_WIDTH-1:0] END_X,
  input  logic [Y_RES_WIDTH-1:0] START_Y,
  input  logic [Y_RES_WIDTH-1:0] END_Y,
  input  logic [PIX_W-1:0]       BG_COLOR,
  input  logic                   in_vs,
  input  logic                   in_de,
  input  logic [PIX_W-1:0]       in_data,
  input  logic                   tim_vs,
  input  logic                   tim_de,
  output logic                   post_vs,
  output logic                   post_de,
  output logic [PIX_W-1:0]       post_data,
  output logic                   underflow,
  output logic                   overflow
);

  localparam logic [X_RES_WIDTH-1:0] H_LAST = X_RES_WIDTH'(H_DISP - 12'd1);
  localparam logic [Y_RES_WIDTH-1:0] V_LAST = Y_RES_WIDTH'(V_DISP - 12'd1);

  logic                   in_vs_d;
  logic                   tim_vs_d;
  logic                   flush;
  logic                   resync;
  logic [X_RES_WIDTH-1:0] h_cnt;
  logic [Y_RES_WIDTH-1:0] v_cnt;
  logic                   rect_hit;
  logic                   in_win;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  pixel_t                 fifo_rdata;
  logic                   post_vs_p1;
  logic                   post_de_p1;
  logic                   pop_p1;
  pixel_t                 fill_p1;
  logic                   underflow_q;
  logic                   overflow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_vs_d  <= 1'b0;
      tim_vs_d <= 1'b0;
    end else begin
      in_vs_d  <= in_vs;
      tim_vs_d <= tim_vs;
    end
  end

  assign flush  = in_vs && !in_vs_d;
  assign resync = tim_vs && !tim_vs_d;

  // Resync outranks the tim_de increment so a mid-line tim_vs restarts the frame cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (resync) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tim_de) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  assign rect_hit = (h_cnt >= START_X) && (h_cnt < END_X) &&
                    (v_cnt >= START_Y) && (v_cnt < END_Y);
  assign in_win   = tim_de && (!EN || rect_hit);
  assign pop      = in_win && !fifo_empty && !flush;

  vp_sync_fifo #(
    .FIFO_AW (FIFO_AW),
    .DATA_W  (PIX_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (in_de),
    .wr_data (in_data),
    .pop     (pop),
    .flush   (flush),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // ---- stage p1: timing copies, pop marker and fill colour ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_vs_p1 <= 1'b0;
      post_de_p1 <= 1'b0;
      pop_p1     <= 1'b0;
      fill_p1    <= PIX_BLACK;
    end else begin
      post_vs_p1 <= tim_vs;
      post_de_p1 <= tim_de;
      pop_p1     <= pop;
      fill_p1    <= tim_de ? BG_COLOR : PIX_BLACK;
    end
  end

  // A flush suppresses both the dropped-push and the empty-read error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (in_win && fifo_empty && !flush)           underflow_q <= 1'b1;
      if (in_de && fifo_full && !pop && !flush)     overflow_q  <= 1'b1;
    end
  end

  assign post_vs   = post_vs_p1;
  assign post_de   = post_de_p1;
  assign post_data = pop_p1 ? fifo_rdata : fill_p1;
  assign underflow = underflow_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_region_embedder.sv
// Directed bench for region_embedder on a 16x8 frame with a 4..8 x 2..4 window.
module tb_region_embedder;

  localparam logic [23:0] BG = 24'h102030;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        EN;
  logic [10:0] START_X, END_X, START_Y, END_Y;
  logic [23:0] BG_COLOR;
  logic        in_vs, in_de;
  logic [23:0] in_data;
  logic        tim_vs, tim_de;
  logic        post_vs, post_de;
  logic [23:0] post_data;
  logic        underflow, overflow;

  int          n_assert;
  int          n_fail;
  int          cyc;
  logic [23:0] mq[$];
  logic [23:0] win_log[$];
  logic [23:0] seg[6];
  bit          m_uf, m_ov, m_ivs_d, m_tvs_d;
  int          m_h, m_v;

  region_embedder #(
    .H_DISP      (12'd16),
    .V_DISP      (12'd8),
    .X_RES_WIDTH (11),
    .Y_RES_WIDTH (11),
    .FIFO_AW     (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .EN        (EN),
    .START_X   (START_X),
    .END_X     (END_X),
    .START_Y   (START_Y),
    .END_Y     (END_Y),
    .BG_COLOR  (BG_COLOR),
    .in_vs     (in_vs),
    .in_de     (in_de),
    .in_data   (in_data),
    .tim_vs    (tim_vs),
    .tim_de    (tim_de),
    .post_vs   (post_vs),
    .post_de   (post_de),
    .post_data (post_data),
    .underflow (underflow),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_uf = 1'b0;
    m_ov = 1'b0;
    m_h = 0;
    m_v = 0;
    m_ivs_d = 1'b0;
    m_tvs_d = 1'b0;
  endtask

  // One clock of stimulus; expected outputs come from a behavioural model of the frame.
  task automatic step(input bit tvs, input bit tde, input bit ivs, input bit ide,
                      input logic [23:0] idata);
    bit          flush, resync, win, was_empty;
    logic [23:0] exp;
    tim_vs = tvs; tim_de = tde; in_vs = ivs; in_de = ide; in_data = idata;
    flush  = ivs && !m_ivs_d;
    resync = tvs && !m_tvs_d;
    win    = tde && (!EN || (m_h >= int'(START_X) && m_h < int'(END_X) &&
                             m_v >= int'(START_Y) && m_v < int'(END_Y)));
    was_empty = (mq.size() == 0);
    exp = tde ? BG : 24'h0;
    if (flush) begin
      mq.delete();
    end else begin
      if (win && !was_empty) exp = mq.pop_front();
      else if (win) m_uf = 1'b1;
      if (ide) begin
        if (mq.size() < 16) mq.push_back(idata);
        else m_ov = 1'b1;
      end
    end
    if (resync) begin
      m_h = 0; m_v = 0;
    end else if (tde) begin
      if (m_h == 15) begin
        m_h = 0;
        m_v = (m_v == 7) ? 0 : m_v + 1;
      end else begin
        m_h++;
      end
    end
    m_ivs_d = ivs;
    m_tvs_d = tvs;
    @(posedge clk); #1;
    cyc++;
    if (win) win_log.push_back(post_data);
    chk($sformatf("post_vs@%0d", cyc), 24'(post_vs), 24'(tvs));
    chk($sformatf("post_de@%0d", cyc), 24'(post_de), 24'(tde));
    chk($sformatf("post_data@%0d", cyc), post_data, exp);
    chk($sformatf("underflow@%0d", cyc), 24'(underflow), 24'(m_uf));
    chk($sformatf("overflow@%0d", cyc), 24'(overflow), 24'(m_ov));
  endtask

  task automatic push_pixels(input int n, input logic [23:0] base);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1, base + 24'(i));
    step(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic frame(input bit push_during, input logic [23:0] pbase);
    int k;
    k = 0;
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 16; c++) begin
        step(1'b0, 1'b1, 1'b0, push_during, pbase + 24'(k));
        k++;
      end
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tim_vs = 1'b0; tim_de = 1'b0; in_vs = 1'b0; in_de = 1'b0; in_data = 24'h0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_assert = 0; n_fail = 0; cyc = 0;
    rst_n = 1'b0; EN = 1'b1;
    START_X = 11'd4; END_X = 11'd8; START_Y = 11'd2; END_Y = 11'd4;
    BG_COLOR = BG;
    in_vs = 1'b0; in_de = 1'b0; in_data = 24'h0; tim_vs = 1'b0; tim_de = 1'b0;
    model_reset();

    // Reset values
    #3;
    chk("rst post_vs", 24'(post_vs), 24'h0);
    chk("rst post_de", 24'(post_de), 24'h0);
    chk("rst post_data", post_data, 24'h0);
    chk("rst underflow", 24'(underflow), 24'h0);
    chk("rst overflow", 24'(overflow), 24'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset mid-line clears outputs asynchronously; first post_de lags tim_de by one clock
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    chk("midline bg", post_data, BG);
    #2 rst_n = 1'b0;
    tim_de = 1'b0;
    #1;
    chk("async post_de", 24'(post_de), 24'h0);
    chk("async post_data", post_data, 24'h0);
    chk("async post_vs", 24'(post_vs), 24'h0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    tim_de = 1'b1;
    #1;
    chk("lag post_de", 24'(post_de), 24'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    chk("lag post_de after", 24'(post_de), 24'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);

    // 8 pixels fill rows 2-3, columns 4-7
    push_pixels(8, 24'h000001);
    win_log.delete();
    frame(1'b0, 24'h0);
    for (int i = 0; i < 8; i++) chk("win8", win_log[i], 24'(i + 1));
    chk("win8 underflow", 24'(underflow), 24'h0);

    // Only 3 pixels: 4th window pixel is background and underflow sticks
    push_pixels(3, 24'h000031);
    win_log.delete();
    frame(1'b0, 24'h0);
    chk("short w0", win_log[0], 24'h000031);
    chk("short w2", win_log[2], 24'h000033);
    chk("short w3", win_log[3], BG);
    chk("short underflow", 24'(underflow), 24'h1);
    win_log.delete();
    frame(1'b0, 24'h0);
    chk("empty w0", win_log[0], BG);
    chk("underflow sticky", 24'(underflow), 24'h1);

    // 20 pixels into a 16-deep FIFO: overflow, then only 1..16 appear
    do_reset();
    push_pixels(16, 24'h000001);
    chk("full no overflow", 24'(overflow), 24'h0);
    push_pixels(4, 24'h000011);
    chk("overflow set", 24'(overflow), 24'h1);
    win_log.delete();
    frame(1'b0, 24'h0);
    frame(1'b0, 24'h0);
    for (int i = 0; i < 16; i++) chk("ovf win", win_log[i], 24'(i + 1));
    win_log.delete();
    frame(1'b0, 24'h0);
    chk("ovf drained", win_log[0], BG);

    // Passthrough with a full FIFO and concurrent push/pop every active cycle
    do_reset();
    push_pixels(16, 24'h000100);
    EN = 1'b0;
    win_log.delete();
    frame(1'b1, 24'h000200);
    for (int i = 0; i < 16; i++) chk("pass row0", win_log[i], 24'h000100 + 24'(i));
    chk("pass row1 c0", win_log[16], 24'h000200);
    chk("pass overflow", 24'(overflow), 24'h0);
    chk("pass underflow", 24'(underflow), 24'h0);
    win_log.delete();
    frame(1'b0, 24'h0);
    for (int i = 0; i < 16; i++) chk("pass drain", win_log[i], 24'h000270 + 24'(i));
    chk("pass empty bg", win_log[16], BG);
    chk("pass underflow set", 24'(underflow), 24'h1);
    EN = 1'b1;

    // in_vs rising edge flushes leftovers and beats a same-cycle push
    push_pixels(5, 24'h000050);
    step(1'b0, 1'b0, 1'b1, 1'b1, 24'hBADBAD);
    step(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
    push_pixels(8, 24'hAA0000);
    win_log.delete();
    frame(1'b0, 24'h0);
    chk("flush first", win_log[0], 24'hAA0000);
    chk("flush last", win_log[7], 24'hAA0007);

    // tim_vs rising edge mid-line restarts h_cnt
    START_Y = 11'd0; END_Y = 11'd1;
    push_pixels(4, 24'h000070);
    step(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
    repeat (6) step(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
      seg[i] = post_data;
    end
    chk("resync c0", seg[0], BG);
    chk("resync c3", seg[3], BG);
    chk("resync c4", seg[4], 24'h000072);
    chk("resync c5", seg[5], 24'h000073);

    // Flush coinciding with an in-window pop gives background
    push_pixels(2, 24'h000080);
    step(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
    repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 24'h0);
    chk("flush pop bg", post_data, BG);
    step(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    chk("after flush bg", post_data, BG);
    step(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
